hilo_muldiv_ctrl: RTL and testbench
===================================

// Module: hilo_muldiv_ctrl
// PURPOSE
//  Sequencer between the multicycle control unit and the iterative mult/div units.
//  Accepts DIV/MULT/MTHI/MTLO ops, launches the selected unit with a one-cycle start pulse, and waits for completion.
//  Commits results into the architectural HI/LO registers and exposes busy/ready so the control unit stalls.
//  Flags divide-by-zero and unit timeout as single-cycle exception pulses.
// PARAMETERS
//  TIMEOUT  40  max WAIT cycles before abort (must exceed worst-case unit latency, 33)
//  CNT_W    6   width of WAIT cycle counter
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high
//  op_valid     in   1   op request from control unit
//  op_code      in   3   0 NOP, 1 DIV, 2 MULT, 3 MTHI, 4 MTLO, 5-7 ignored
//  rs_val       in   32  operand A / MTHI/MTLO source
//  rt_val       in   32  operand B
//  op_ready     out  1   high only in IDLE; op accepted when op_valid&&op_ready
//  busy         out  1   high in LAUNCH/WAIT/COMMIT
//  done         out  1   one-cycle pulse when HI/LO committed (DIV/MULT)
//  hi_out       out  32  architectural HI (MFHI source)
//  lo_out       out  32  architectural LO (MFLO source)
//  div_zero_exc out  1   one-cycle pulse, DIV aborted on zero divisor
//  timeout_exc  out  1   one-cycle pulse, unit failed to finish in TIMEOUT cycles
//  div_start    out  1   one-cycle start to divider
//  div_a,div_b  out  32  registered divider operands, stable from LAUNCH until back in IDLE
//  div_hi,div_lo in  32  divider remainder / quotient
//  div_stop     in   1   divider finished (level; may stay high from previous op)
//  div_zero     in   1   divider saw zero divisor
//  mult_start   out  1   one-cycle start to multiplier
//  mult_a,mult_b out 32  registered multiplier operands
//  mult_hi,mult_lo in 32 product upper / lower word
//  mult_stop    in   1   multiplier finished (level)
// BEHAVIOUR
//  Reset (async): state IDLE; HI=LO=0; all pulses, starts, operands, counter = 0; op_ready=1.
//  Reset mid-operation: abandon op, no commit, no exception pulse.
//  States: IDLE -> LAUNCH -> WAIT -> COMMIT -> IDLE; WAIT -> IDLE on abort.
//  IDLE: MTHI/MTLO write HI/LO at the accepting edge (latency 1), stay IDLE.
//   DIV/MULT: latch rs/rt into operand regs and unit select; go LAUNCH. NOP/5-7: no effect.
//  LAUNCH: assert div_start or mult_start for exactly one cycle; clear counter; go WAIT.
//  WAIT: counter increments each cycle.
//   Ignore stop/zero in the first WAIT cycle (cnt==0): stale level from previous op.
//   DIV, div_zero=1 (cnt>=1): pulse div_zero_exc next cycle, HI/LO unchanged, -> IDLE.
//   stop=1 (cnt>=1): -> COMMIT. Zero check has priority over stop in the same cycle.
//   cnt==TIMEOUT with no stop: pulse timeout_exc, HI/LO unchanged, -> IDLE.
//  COMMIT: HI<=unit hi, LO<=unit lo; done pulse; -> IDLE (op_ready next cycle).
//  No op is accepted while busy; op_valid is ignored, not queued.
//  Results are passed through unmodified; sign fix-up is the unit's job.
//  Counter saturates at TIMEOUT; no wrap.
// STRUCTURE
//  muldiv_pkg: op_code localparams (OP_NOP..OP_MTLO), state encoding (IDLE,LAUNCH,WAIT,COMMIT), TIMEOUT default.
//  Sub-module hilo_regfile: HI/LO pair, async reset to 0.
//   Write ports: mthi, mtlo, commit(hi,lo). Commit and mt* are mutually exclusive by construction.
//  FSM, counter and operand regs stay in the top.
// TESTING
//  Use behavioural div/mult models with 33-cycle latency; div_stop held high after finish.
//  1. DIV rs=7, rt=-2 -> one div_start pulse, done; LO=0xFFFFFFFD, HI=0x00000001.
//  2. DIV -7/2 immediately after test 1 (div_stop still high) -> no early commit;
//     LO=0xFFFFFFFD, HI=0xFFFFFFFF after full latency.
//  3. MTHI 0xDEADBEEF, MTLO 0x12345678 -> hi_out/lo_out update next cycle; DIV 5/0 ->
//     div_zero_exc pulse, HI/LO keep 0xDEADBEEF/0x12345678, op_ready returns.
//  4. MULT 0x80000000 * 2 -> HI=0xFFFFFFFF, LO=0x00000000.
//     MTLO issued during busy is not accepted; LO is unchanged by it.
//  5. Model never raises stop -> timeout_exc exactly TIMEOUT cycles into WAIT; no commit.
//  6. Assert reset at WAIT cycle 10 -> HI=LO=0, IDLE, no done/exception pulse.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO mult/div sequencer: op codes, FSM states
// and default sizing.
package muldiv_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_MULT = 3'd2;
    localparam logic [2:0] OP_MTHI = 3'd3;
    localparam logic [2:0] OP_MTLO = 3'd4;

    // Must exceed the worst-case unit latency of 33 WAIT cycles.
    localparam int TIMEOUT_DEFAULT = 40;
    localparam int CNT_W_DEFAULT   = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

endpackage

// File: rtl/hilo_regfile.sv
// Architectural HI/LO register pair with MTHI/MTLO write ports and a combined
// result-commit port; commit never coincides with an MT write.
module hilo_regfile
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              mthi_we,
    input  logic              mtlo_we,
    input  logic [DATA_W-1:0] mt_val,
    input  logic              commit_we,
    input  logic [DATA_W-1:0] commit_hi,
    input  logic [DATA_W-1:0] commit_lo,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        hi_d = hi_q;
        lo_d = lo_q;
        if (commit_we) begin
            hi_d = commit_hi;
            lo_d = commit_lo;
        end else begin
            if (mthi_we) hi_d = mt_val;
            if (mtlo_we) lo_d = mt_val;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Sequencer between the multicycle control unit and the iterative mult/div
// units: launches a unit, waits for it, commits HI/LO or raises an exception.
module hilo_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [2:0]        op_code,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic              op_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic              div_zero_exc,
    output logic              timeout_exc,
    output logic              div_start,
    output logic [DATA_W-1:0] div_a,
    output logic [DATA_W-1:0] div_b,
    input  logic [DATA_W-1:0] div_hi,
    input  logic [DATA_W-1:0] div_lo,
    input  logic              div_stop,
    input  logic              div_zero,
    output logic              mult_start,
    output logic [DATA_W-1:0] mult_a,
    output logic [DATA_W-1:0] mult_b,
    input  logic [DATA_W-1:0] mult_hi,
    input  logic [DATA_W-1:0] mult_lo,
    input  logic              mult_stop
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              unit_div_q, unit_div_d;
    logic [DATA_W-1:0] div_a_q, div_a_d, div_b_q, div_b_d;
    logic [DATA_W-1:0] mult_a_q, mult_a_d, mult_b_q, mult_b_d;
    logic              div_start_q, div_start_d, mult_start_q, mult_start_d;
    logic              done_q, done_d, div_zero_exc_q, div_zero_exc_d;
    logic              timeout_exc_q, timeout_exc_d;
    logic              mthi_we, mtlo_we, commit_we;

    logic accept, unit_op, unit_stop, wait_armed;
    logic zero_abort, stop_commit, timeout_abort;

    assign accept     = op_valid && (state_q == ST_IDLE);
    assign unit_op    = (op_code == OP_DIV) || (op_code == OP_MULT);
    assign unit_stop  = unit_div_q ? div_stop : mult_stop;
    // The first WAIT cycle still sees the stop/zero level left by the previous op.
    assign wait_armed = (state_q == ST_WAIT) && (cnt_q != '0);

    assign zero_abort    = wait_armed && unit_div_q && div_zero;
    assign stop_commit   = wait_armed && !zero_abort && unit_stop;
    assign timeout_abort = wait_armed && !zero_abort && !unit_stop
                           && (cnt_q == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept && unit_op) state_d = ST_LAUNCH;
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (stop_commit)                        state_d = ST_COMMIT;
                else if (zero_abort || timeout_abort)   state_d = ST_IDLE;
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_ready       = (state_q == ST_IDLE);
        busy           = (state_q != ST_IDLE);
        mthi_we        = accept && (op_code == OP_MTHI);
        mtlo_we        = accept && (op_code == OP_MTLO);
        commit_we      = (state_q == ST_COMMIT);
        div_start_d    = accept && (op_code == OP_DIV);
        mult_start_d   = accept && (op_code == OP_MULT);
        done_d         = commit_we;
        div_zero_exc_d = zero_abort;
        timeout_exc_d  = timeout_abort;
    end

    always_comb begin
        cnt_d      = cnt_q;
        unit_div_d = unit_div_q;
        div_a_d    = div_a_q;
        div_b_d    = div_b_q;
        mult_a_d   = mult_a_q;
        mult_b_d   = mult_b_q;
        if (state_q == ST_LAUNCH)
            cnt_d = '0;
        else if ((state_q == ST_WAIT) && (cnt_q != CNT_W'(TIMEOUT)))
            cnt_d = cnt_q + CNT_W'(1);
        if (div_start_d) begin
            unit_div_d = 1'b1;
            div_a_d    = rs_val;
            div_b_d    = rt_val;
        end
        if (mult_start_d) begin
            unit_div_d = 1'b0;
            mult_a_d   = rs_val;
            mult_b_d   = rt_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q          <= '0;
            unit_div_q     <= 1'b0;
            div_a_q        <= '0;
            div_b_q        <= '0;
            mult_a_q       <= '0;
            mult_b_q       <= '0;
            div_start_q    <= 1'b0;
            mult_start_q   <= 1'b0;
            done_q         <= 1'b0;
            div_zero_exc_q <= 1'b0;
            timeout_exc_q  <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            unit_div_q     <= unit_div_d;
            div_a_q        <= div_a_d;
            div_b_q        <= div_b_d;
            mult_a_q       <= mult_a_d;
            mult_b_q       <= mult_b_d;
            div_start_q    <= div_start_d;
            mult_start_q   <= mult_start_d;
            done_q         <= done_d;
            div_zero_exc_q <= div_zero_exc_d;
            timeout_exc_q  <= timeout_exc_d;
        end
    end

    hilo_regfile u_hilo (
        .clk       (clk),
        .reset     (reset),
        .mthi_we   (mthi_we),
        .mtlo_we   (mtlo_we),
        .mt_val    (rs_val),
        .commit_we (commit_we),
        .commit_hi (unit_div_q ? div_hi : mult_hi),
        .commit_lo (unit_div_q ? div_lo : mult_lo),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    assign div_start    = div_start_q;
    assign mult_start   = mult_start_q;
    assign div_a        = div_a_q;
    assign div_b        = div_b_q;
    assign mult_a       = mult_a_q;
    assign mult_b       = mult_b_q;
    assign done         = done_q;
    assign div_zero_exc = div_zero_exc_q;
    assign timeout_exc  = timeout_exc_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Bench for hilo_muldiv_ctrl: 33-cycle behavioural div/mult units, a cycle-scheduled
// expectation model checked every cycle, and literal HI/LO checks per scenario.
module tb_hilo_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int TMO = 40;
    localparam int LAT = 33;
    localparam int ZLAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] rs_val, rt_val;
    logic        op_ready, busy, done, div_zero_exc, timeout_exc;
    logic [31:0] hi_out, lo_out;
    logic        div_start, mult_start;
    logic [31:0] div_a, div_b, mult_a, mult_b;
    logic [31:0] div_hi = '0, div_lo = '0, mult_hi = '0, mult_lo = '0;
    logic        div_stop = 1'b0, div_zero = 1'b0, mult_stop = 1'b0;

    always #5 clk = ~clk;

    hilo_muldiv_ctrl #(.TIMEOUT(TMO), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .rs_val(rs_val), .rt_val(rt_val), .op_ready(op_ready), .busy(busy),
        .done(done), .hi_out(hi_out), .lo_out(lo_out),
        .div_zero_exc(div_zero_exc), .timeout_exc(timeout_exc),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_hi(div_hi), .div_lo(div_lo), .div_stop(div_stop), .div_zero(div_zero),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_hi(mult_hi), .mult_lo(mult_lo), .mult_stop(mult_stop)
    );

    // Behavioural units: result level appears LAT cycles into WAIT; the stop level
    // from the previous op lingers through the first WAIT cycle.
    int          d_age = 0, m_age = 0, d_lat = LAT;
    bit          d_run = 0, m_run = 0, mult_hang = 0;
    logic [31:0] d_a = '0, d_b = '0, m_a = '0, m_b = '0;
    logic signed [63:0] m_prod;

    always @(posedge clk) begin
        if (div_start) begin
            d_run = 1; d_age = 0; d_a = div_a; d_b = div_b;
            d_lat = (div_b == 32'd0) ? ZLAT : LAT;
        end else if (d_run) begin
            d_age++;
            if (d_age == 1) begin div_stop <= 1'b0; div_zero <= 1'b0; end
            if (d_age == d_lat) begin
                d_run = 0;
                div_stop <= 1'b1;
                if (d_b == 32'd0) begin
                    div_zero <= 1'b1; div_hi <= 32'hBAD0BAD0; div_lo <= 32'hBAD1BAD1;
                end else begin
                    div_lo <= $signed(d_a) / $signed(d_b);
                    div_hi <= $signed(d_a) % $signed(d_b);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (mult_start) begin
            m_run = 1; m_age = 0; m_a = mult_a; m_b = mult_b;
        end else if (m_run) begin
            m_age++;
            if (m_age == 1) mult_stop <= 1'b0;
            if (m_age == LAT) begin
                m_run = 0;
                if (!mult_hang) begin
                    m_prod = 64'(signed'(m_a)) * 64'(signed'(m_b));
                    mult_stop <= 1'b1;
                    mult_hi <= m_prod[63:32];
                    mult_lo <= m_prod[31:0];
                end
            end
        end
    end

    // Expectation model: events scheduled by absolute cycle number.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          busy_from = -1, busy_to = -1, done_at = -1, zexc_at = -1, texc_at = -1;
    int          apply_at = -1;
    bit          apply_hi = 0, apply_lo = 0, unit_div = 0, exp_busy;
    logic [31:0] apply_hi_v = '0, apply_lo_v = '0, exp_hi = '0, exp_lo = '0;
    logic [31:0] op_a = '0, op_b = '0;
    int          nchecks = 0, nfail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc == apply_at) begin
            if (apply_hi) exp_hi = apply_hi_v;
            if (apply_lo) exp_lo = apply_lo_v;
        end
        exp_busy = (cyc >= busy_from) && (cyc < busy_to);
        check("hi_out",       hi_out,              exp_hi);
        check("lo_out",       lo_out,              exp_lo);
        check("op_ready",     32'(op_ready),       32'(!exp_busy));
        check("busy",         32'(busy),           32'(exp_busy));
        check("done",         32'(done),           32'(cyc == done_at));
        check("div_zero_exc", 32'(div_zero_exc),   32'(cyc == zexc_at));
        check("timeout_exc",  32'(timeout_exc),    32'(cyc == texc_at));
        check("div_start",    32'(div_start),      32'(cyc == busy_from && unit_div));
        check("mult_start",   32'(mult_start),     32'(cyc == busy_from && !unit_div));
        if (exp_busy && unit_div) begin
            check("div_a", div_a, op_a);
            check("div_b", div_b, op_b);
        end
        if (exp_busy && !unit_div) begin
            check("mult_a", mult_a, op_a);
            check("mult_b", mult_b, op_b);
        end
    end

    // Issue one op in IDLE; schedule what must happen and when.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit hang);
        int acc;
        logic signed [63:0] p;
        @(negedge clk); #1;
        acc = cyc + 1;
        op_valid = 1'b1; op_code = op; rs_val = a; rt_val = b;
        if (op == OP_MTHI || op == OP_MTLO) begin
            apply_at = acc; apply_hi = (op == OP_MTHI); apply_lo = (op == OP_MTLO);
            apply_hi_v = a; apply_lo_v = a;
        end else if (op == OP_DIV || op == OP_MULT) begin
            busy_from = acc; unit_div = (op == OP_DIV); op_a = a; op_b = b;
            mult_hang = hang;
            if (op == OP_DIV && b == 32'd0) begin
                zexc_at = acc + ZLAT + 2; busy_to = zexc_at;
            end else if (hang) begin
                texc_at = acc + TMO + 2; busy_to = texc_at;
            end else begin
                done_at = acc + LAT + 3; busy_to = done_at; apply_at = done_at;
                apply_hi = 1; apply_lo = 1;
                if (op == OP_DIV) begin
                    apply_lo_v = $signed(a) / $signed(b);
                    apply_hi_v = $signed(a) % $signed(b);
                end else begin
                    p = 64'(signed'(a)) * 64'(signed'(b));
                    apply_hi_v = p[63:32]; apply_lo_v = p[31:0];
                end
            end
        end
        @(posedge clk); #1;
        op_valid = 1'b0; op_code = OP_NOP;
    endtask

    task automatic wait_op();
        while (cyc < busy_to) @(negedge clk);
        #1;
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; op_valid = 1'b0; op_code = OP_NOP; rs_val = '0; rt_val = '0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: DIV 7 / -2
        start_op(OP_DIV, 32'd7, 32'hFFFFFFFE, 0);
        wait_op();
        check("t1_lo", lo_out, 32'hFFFFFFFD);
        check("t1_hi", hi_out, 32'h00000001);

        // 2: DIV -7 / 2 back-to-back, stale div_stop still high
        start_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 0);
        wait_op();
        check("t2_lo", lo_out, 32'hFFFFFFFD);
        check("t2_hi", hi_out, 32'hFFFFFFFF);

        // 3: MTHI/MTLO, ignored codes, then divide by zero
        start_op(OP_MTHI, 32'hDEADBEEF, 32'd0, 0);
        start_op(OP_MTLO, 32'h12345678, 32'd0, 0);
        check("t3_mthi", hi_out, 32'hDEADBEEF);
        check("t3_mtlo", lo_out, 32'h12345678);
        start_op(OP_NOP, 32'h11111111, 32'd0, 0);
        start_op(3'd6, 32'h22222222, 32'd0, 0);
        start_op(OP_DIV, 32'd5, 32'd0, 0);
        wait_op();
        check("t3_hi", hi_out, 32'hDEADBEEF);
        check("t3_lo", lo_out, 32'h12345678);

        // 4: MULT 0x80000000 * 2 with an MTLO attempted while busy
        start_op(OP_MULT, 32'h80000000, 32'd2, 0);
        repeat (5) @(negedge clk);
        #1 op_valid = 1'b1; op_code = OP_MTLO; rs_val = 32'hCAFEF00D;
        repeat (5) @(negedge clk);
        #1 op_valid = 1'b0; op_code = OP_NOP;
        wait_op();
        check("t4_hi", hi_out, 32'hFFFFFFFF);
        check("t4_lo", lo_out, 32'h00000000);

        // 5: unit never finishes -> timeout
        start_op(OP_MULT, 32'd3, 32'd4, 1);
        wait_op();
        check("t5_hi", hi_out, 32'hFFFFFFFF);
        check("t5_lo", lo_out, 32'h00000000);

        // 6: reset during WAIT cycle 10
        start_op(OP_DIV, 32'd100, 32'd7, 0);
        while (cyc < busy_from + 11) @(negedge clk);
        @(posedge clk); #2;
        reset = 1'b1;
        busy_from = -1; busy_to = -1; done_at = -1; zexc_at = -1; texc_at = -1;
        apply_at = -1; exp_hi = '0; exp_lo = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check("t6_hi", hi_out, 32'h0);
        check("t6_lo", lo_out, 32'h0);
        check("t6_ready", 32'(op_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end

endmodule
